// File: rtl/hash_pkg.sv
// Shared definitions for the cuckoo hash write-back slice.
// Holds the table geometry, request op encoding, write-back FSM states,
// slot-selection actions, the slot entry struct and a saturating increment
// helper used by the optional statistics counters (HASH_WB_STATS_EN).
package hash_pkg;

  localparam int DATA_WIDTH         = 4;
  localparam int KEY_WIDTH          = 2;
  localparam int NUMBER_OF_TABLES   = 4;
  localparam int MAX_HASH_ADR_WIDTH = 2;
  localparam int MAX_KICKS          = 7;
  localparam int KW                 = $clog2(MAX_KICKS + 1);
  localparam int TW                 = $clog2(NUMBER_OF_TABLES);

  typedef enum logic [1:0] {
    OP_LOOKUP = 2'd0,
    OP_INSERT = 2'd1,
    OP_DELETE = 2'd2,
    OP_RSVD   = 2'd3
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_EVICT = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    ACT_MATCH  = 2'd0,
    ACT_EMPTY  = 2'd1,
    ACT_VICTIM = 2'd2
  } act_e;

  typedef struct packed {
    logic [KEY_WIDTH-1:0]  key;
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
  } entry_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    if (en && (v != 32'hFFFF_FFFF)) return v + 32'd1;
    return v;
  endfunction

endpackage

// File: rtl/hash_write_back_stage_if.sv
// Request / response / reinsert bundle of the hash write-back stage.
//   req_*   : request from the forwarding updater (valid/ready handshake)
//   resp_*  : response strobe and status (no backpressure)
//   reins_* : evicted entry returned to the hash front end (valid/ready)
// master = upstream/front-end side, slave = write-back stage.
interface hash_write_back_stage_if;
  import hash_pkg::*;

  logic                                               req_valid;
  logic                                               req_ready;
  logic [1:0]                                         req_op;
  logic [KEY_WIDTH-1:0]                               req_key;
  logic [DATA_WIDTH-1:0]                              req_data;
  logic [KW-1:0]                                      req_kick;
  logic [NUMBER_OF_TABLES-1:0][MAX_HASH_ADR_WIDTH-1:0] req_hash_adr;

  logic                                               resp_valid;
  logic                                               resp_hit;
  logic                                               resp_fail;
  logic [DATA_WIDTH-1:0]                              resp_data;

  logic                                               reins_valid;
  logic                                               reins_ready;
  logic [KEY_WIDTH-1:0]                               reins_key;
  logic [DATA_WIDTH-1:0]                              reins_data;
  logic [KW-1:0]                                      reins_kick;

  modport master (
    output req_valid, req_op, req_key, req_data, req_kick, req_hash_adr, reins_ready,
    input  req_ready, resp_valid, resp_hit, resp_fail, resp_data,
           reins_valid, reins_key, reins_data, reins_kick
  );

  modport slave (
    input  req_valid, req_op, req_key, req_data, req_kick, req_hash_adr, reins_ready,
    output req_ready, resp_valid, resp_hit, resp_fail, resp_data,
           reins_valid, reins_key, reins_data, reins_kick
  );

endinterface

// File: rtl/hash_slot_select.sv
// Combinational slot selection for one request.
//   slots     : forwarding-corrected contents of the addressed slot per table
//   key       : request key
//   vic       : round-robin victim table
//   hit       : key present in at least one valid slot
//   match_idx : lowest table holding the key (0 when no hit)
//   ins_act   : insert action (overwrite match / fill empty / evict victim)
//   ins_idx   : table targeted by an insert
module hash_slot_select
  import hash_pkg::*;
(
  input  entry_t [NUMBER_OF_TABLES-1:0] slots,
  input  logic   [KEY_WIDTH-1:0]        key,
  input  logic   [TW-1:0]               vic,
  output logic                          hit,
  output logic   [TW-1:0]               match_idx,
  output act_e                          ins_act,
  output logic   [TW-1:0]               ins_idx
);

  logic          empty_found;
  logic [TW-1:0] empty_idx;

  // Scan from the top so the lowest qualifying table is the last one written.
  always_comb begin
    hit         = 1'b0;
    match_idx   = '0;
    empty_found = 1'b0;
    empty_idx   = '0;
    for (int t = NUMBER_OF_TABLES - 1; t >= 0; t--) begin
      if (slots[t].valid && (slots[t].key == key)) begin
        hit       = 1'b1;
        match_idx = TW'(t);
      end
      if (!slots[t].valid) begin
        empty_found = 1'b1;
        empty_idx   = TW'(t);
      end
    end
  end

  always_comb begin
    ins_act = ACT_VICTIM;
    ins_idx = vic;
    if (hit) begin
      ins_act = ACT_MATCH;
      ins_idx = match_idx;
    end else if (empty_found) begin
      ins_act = ACT_EMPTY;
      ins_idx = empty_idx;
    end
  end

endmodule

// File: rtl/hash_write_back_stage.sv
// Write-back / decision stage of the multi-table cuckoo hash pipeline.
// Decides hit/miss and target slot per request, issues the table writes,
// mirrors them one cycle later as the forwarding feed, and parks evicted
// entries in a stash until the front end takes them back.
// Ports:
//   clk_sys, rst_b (synchronous, active-low), clk_en (0 freezes everything)
//   bus            : request / response / reinsert bundle (slave side)
//   corr_*         : corrected slot contents per table
//   wr_*           : table write port per table (registered)
//   fwd_*          : wr_* delayed one more cycle
//   stats_*        : saturating event counters, only with HASH_WB_STATS_EN
//
// state    | meaning
// ST_IDLE  | accepting requests
// ST_EVICT | stash holds an evicted entry, offered on reins_*, requests stalled
module hash_write_back_stage
  import hash_pkg::*;
(
  input  logic                                                clk_sys,
  input  logic                                                rst_b,
  input  logic                                                clk_en,
  hash_write_back_stage_if.slave                              bus,
  input  logic [NUMBER_OF_TABLES-1:0][KEY_WIDTH-1:0]          corr_key,
  input  logic [NUMBER_OF_TABLES-1:0][DATA_WIDTH-1:0]         corr_data,
  input  logic [NUMBER_OF_TABLES-1:0]                         corr_valid,
  output logic [NUMBER_OF_TABLES-1:0]                         wr_en,
  output logic [NUMBER_OF_TABLES-1:0][MAX_HASH_ADR_WIDTH-1:0] wr_adr,
  output logic [NUMBER_OF_TABLES-1:0][KEY_WIDTH-1:0]          wr_key,
  output logic [NUMBER_OF_TABLES-1:0][DATA_WIDTH-1:0]         wr_data,
  output logic [NUMBER_OF_TABLES-1:0]                         wr_valid,
  output logic [NUMBER_OF_TABLES-1:0][MAX_HASH_ADR_WIDTH-1:0] fwd_hash_adr,
  output logic [NUMBER_OF_TABLES-1:0][DATA_WIDTH-1:0]         fwd_data,
  output logic [NUMBER_OF_TABLES-1:0][KEY_WIDTH-1:0]          fwd_key,
  output logic [NUMBER_OF_TABLES-1:0]                         fwd_updated_mem,
  output logic [NUMBER_OF_TABLES-1:0]                         fwd_valid
`ifdef HASH_WB_STATS_EN
  ,
  output logic [31:0]                                         stats_lookup_hits,
  output logic [31:0]                                         stats_inserts,
  output logic [31:0]                                         stats_evictions,
  output logic [31:0]                                         stats_insert_fails
`endif
);

  state_e                state, state_nxt;
  op_e                   op;
  entry_t [NUMBER_OF_TABLES-1:0] slots;
  logic                  ready, accept;
  logic                  hit;
  logic [TW-1:0]         match_idx, ins_idx, vic;
  act_e                  ins_act;

  logic [NUMBER_OF_TABLES-1:0]                         d_wr_en, d_wr_valid;
  logic [NUMBER_OF_TABLES-1:0][MAX_HASH_ADR_WIDTH-1:0] d_wr_adr;
  logic [NUMBER_OF_TABLES-1:0][KEY_WIDTH-1:0]          d_wr_key;
  logic [NUMBER_OF_TABLES-1:0][DATA_WIDTH-1:0]         d_wr_data;
  logic                  d_resp_valid, d_resp_hit, d_resp_fail, do_evict;
  logic [DATA_WIDTH-1:0] d_resp_data;

  logic                  resp_valid_q, resp_hit_q, resp_fail_q;
  logic [DATA_WIDTH-1:0] resp_data_q;
  logic [KEY_WIDTH-1:0]  stash_key;
  logic [DATA_WIDTH-1:0] stash_data;
  logic [KW-1:0]         stash_kick;

  assign op     = op_e'(bus.req_op);
  assign ready  = (state == ST_IDLE);
  assign accept = bus.req_valid & ready & clk_en;

  always_comb begin
    slots = '0;
    for (int t = 0; t < NUMBER_OF_TABLES; t++) begin
      slots[t].key   = corr_key[t];
      slots[t].data  = corr_data[t];
      slots[t].valid = corr_valid[t];
    end
  end

  hash_slot_select u_slot_select (
    .slots     (slots),
    .key       (bus.req_key),
    .vic       (vic),
    .hit       (hit),
    .match_idx (match_idx),
    .ins_act   (ins_act),
    .ins_idx   (ins_idx)
  );

  always_comb begin
    d_wr_en      = '0;
    d_wr_adr     = '0;
    d_wr_key     = '0;
    d_wr_data    = '0;
    d_wr_valid   = '0;
    d_resp_valid = 1'b0;
    d_resp_hit   = 1'b0;
    d_resp_fail  = 1'b0;
    d_resp_data  = '0;
    do_evict     = 1'b0;
    if (accept) begin
      d_resp_valid = 1'b1;
      d_resp_hit   = hit;
      unique case (op)
        OP_INSERT: begin
          // Out of kicks: the table contents stay untouched and the victim
          // pointer does not move, so the insert simply fails.
          if ((ins_act == ACT_VICTIM) && (bus.req_kick >= KW'(MAX_KICKS))) begin
            d_resp_fail = 1'b1;
          end else begin
            d_wr_en[ins_idx]    = 1'b1;
            d_wr_adr[ins_idx]   = bus.req_hash_adr[ins_idx];
            d_wr_key[ins_idx]   = bus.req_key;
            d_wr_data[ins_idx]  = bus.req_data;
            d_wr_valid[ins_idx] = 1'b1;
            do_evict            = (ins_act == ACT_VICTIM);
          end
        end
        OP_DELETE: begin
          if (hit) begin
            d_wr_en[match_idx]  = 1'b1;
            d_wr_adr[match_idx] = bus.req_hash_adr[match_idx];
            d_wr_key[match_idx] = bus.req_key;
          end
        end
        default: begin
          d_resp_data = hit ? slots[match_idx].data : '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_b) begin
      state <= ST_IDLE;
    end else if (clk_en) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    bus.reins_valid = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (do_evict) state_nxt = ST_EVICT;
      end
      ST_EVICT: begin
        bus.reins_valid = 1'b1;
        if (bus.reins_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!rst_b) begin
      wr_en           <= '0;
      wr_adr          <= '0;
      wr_key          <= '0;
      wr_data         <= '0;
      wr_valid        <= '0;
      fwd_updated_mem <= '0;
      fwd_hash_adr    <= '0;
      fwd_key         <= '0;
      fwd_data        <= '0;
      fwd_valid       <= '0;
      resp_valid_q    <= 1'b0;
      resp_hit_q      <= 1'b0;
      resp_fail_q     <= 1'b0;
      resp_data_q     <= '0;
    end else if (clk_en) begin
      wr_en           <= d_wr_en;
      wr_adr          <= d_wr_adr;
      wr_key          <= d_wr_key;
      wr_data         <= d_wr_data;
      wr_valid        <= d_wr_valid;
      fwd_updated_mem <= wr_en;
      fwd_hash_adr    <= wr_adr;
      fwd_key         <= wr_key;
      fwd_data        <= wr_data;
      fwd_valid       <= wr_valid;
      resp_valid_q    <= d_resp_valid;
      resp_hit_q      <= d_resp_hit;
      resp_fail_q     <= d_resp_fail;
      resp_data_q     <= d_resp_data;
    end
  end

  // Stash is cleared once the front end takes it so reins_* read 0 when idle.
  always_ff @(posedge clk_sys) begin
    if (!rst_b) begin
      stash_key  <= '0;
      stash_data <= '0;
      stash_kick <= '0;
      vic        <= '0;
    end else if (clk_en) begin
      if (do_evict) begin
        stash_key  <= slots[ins_idx].key;
        stash_data <= slots[ins_idx].data;
        stash_kick <= bus.req_kick + KW'(1);
        vic        <= (vic == TW'(NUMBER_OF_TABLES - 1)) ? '0 : vic + TW'(1);
      end else if ((state == ST_EVICT) && bus.reins_ready) begin
        stash_key  <= '0;
        stash_data <= '0;
        stash_kick <= '0;
      end
    end
  end

  assign bus.req_ready  = ready;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_hit   = resp_hit_q;
  assign bus.resp_fail  = resp_fail_q;
  assign bus.resp_data  = resp_data_q;
  assign bus.reins_key  = stash_key;
  assign bus.reins_data = stash_data;
  assign bus.reins_kick = stash_kick;

`ifdef HASH_WB_STATS_EN
  logic [31:0] cnt_lookup_hits, cnt_inserts, cnt_evictions, cnt_insert_fails;

  always_ff @(posedge clk_sys) begin
    if (!rst_b) begin
      cnt_lookup_hits  <= '0;
      cnt_inserts      <= '0;
      cnt_evictions    <= '0;
      cnt_insert_fails <= '0;
    end else if (clk_en) begin
      cnt_lookup_hits  <= sat_inc(cnt_lookup_hits,
                                  accept && (op != OP_INSERT) && (op != OP_DELETE) && hit);
      cnt_inserts      <= sat_inc(cnt_inserts, accept && (op == OP_INSERT));
      cnt_evictions    <= sat_inc(cnt_evictions, do_evict);
      cnt_insert_fails <= sat_inc(cnt_insert_fails, d_resp_fail);
    end
  end

  assign stats_lookup_hits  = cnt_lookup_hits;
  assign stats_inserts      = cnt_inserts;
  assign stats_evictions    = cnt_evictions;
  assign stats_insert_fails = cnt_insert_fails;
`endif

endmodule

// File: tb/tb_hash_write_back_stage.sv
module tb_hash_write_back_stage;
  import hash_pkg::*;

  logic clk_sys = 1'b0;
  logic rst_b   = 1'b0;
  logic clk_en  = 1'b1;

  logic [NUMBER_OF_TABLES-1:0][KEY_WIDTH-1:0]          corr_key;
  logic [NUMBER_OF_TABLES-1:0][DATA_WIDTH-1:0]         corr_data;
  logic [NUMBER_OF_TABLES-1:0]                         corr_valid;
  logic [NUMBER_OF_TABLES-1:0]                         wr_en, wr_valid;
  logic [NUMBER_OF_TABLES-1:0][MAX_HASH_ADR_WIDTH-1:0] wr_adr, fwd_hash_adr;
  logic [NUMBER_OF_TABLES-1:0][KEY_WIDTH-1:0]          wr_key, fwd_key;
  logic [NUMBER_OF_TABLES-1:0][DATA_WIDTH-1:0]         wr_data, fwd_data;
  logic [NUMBER_OF_TABLES-1:0]                         fwd_updated_mem, fwd_valid;
`ifdef HASH_WB_STATS_EN
  logic [31:0] stats_lookup_hits, stats_inserts, stats_evictions, stats_insert_fails;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  hash_write_back_stage_if bus ();

  hash_write_back_stage dut (
    .clk_sys         (clk_sys),
    .rst_b           (rst_b),
    .clk_en          (clk_en),
    .bus             (bus),
    .corr_key        (corr_key),
    .corr_data       (corr_data),
    .corr_valid      (corr_valid),
    .wr_en           (wr_en),
    .wr_adr          (wr_adr),
    .wr_key          (wr_key),
    .wr_data         (wr_data),
    .wr_valid        (wr_valid),
    .fwd_hash_adr    (fwd_hash_adr),
    .fwd_data        (fwd_data),
    .fwd_key         (fwd_key),
    .fwd_updated_mem (fwd_updated_mem),
    .fwd_valid       (fwd_valid)
`ifdef HASH_WB_STATS_EN
    ,
    .stats_lookup_hits  (stats_lookup_hits),
    .stats_inserts      (stats_inserts),
    .stats_evictions    (stats_evictions),
    .stats_insert_fails (stats_insert_fails)
`endif
  );

  always #5 clk_sys = ~clk_sys;

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic set_tables(input logic [7:0] keys, input logic [15:0] data, input logic [3:0] valid);
    corr_key   = keys;
    corr_data  = data;
    corr_valid = valid;
  endtask

  // table addresses: t3=1, t2=2, t1=3, t0=2
  task automatic drive_req(input logic [1:0] op, input logic [1:0] key,
                           input logic [3:0] data, input logic [2:0] kick);
    bus.req_valid    = 1'b1;
    bus.req_op       = op;
    bus.req_key      = key;
    bus.req_data     = data;
    bus.req_kick     = kick;
    bus.req_hash_adr = {2'd1, 2'd2, 2'd3, 2'd2};
  endtask

  task automatic test_reset();
    step();
    step();
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0h expected 1", bus.req_ready); end
    n_checks++; if (bus.reins_valid !== 1'b0) begin n_fail++; $display("FAIL reset_reins_valid: got %0h expected 0", bus.reins_valid); end
    n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %0h expected 0", bus.resp_valid); end
    n_checks++; if (wr_en !== 4'b0000) begin n_fail++; $display("FAIL reset_wr_en: got %0h expected 0", wr_en); end
    n_checks++; if (fwd_updated_mem !== 4'b0000) begin n_fail++; $display("FAIL reset_fwd_mem: got %0h expected 0", fwd_updated_mem); end
    n_checks++; if (bus.reins_data !== 4'h0) begin n_fail++; $display("FAIL reset_reins_data: got %0h expected 0", bus.reins_data); end
    rst_b = 1'b1;
  endtask

  task automatic test_lookup();
    // t3 k1 d1, t2 k3 d2, t1 k2 d9, t0 k2 d5 (t0 invalid)
    set_tables({2'd1, 2'd3, 2'd2, 2'd2}, 16'h1295, 4'b1110);
    drive_req(2'd0, 2'd2, 4'h0, 3'd0);
    step();
    n_checks++; if (bus.resp_valid !== 1'b1) begin n_fail++; $display("FAIL lookup_valid: got %0h expected 1", bus.resp_valid); end
    n_checks++; if (bus.resp_hit !== 1'b1) begin n_fail++; $display("FAIL lookup_hit: got %0h expected 1", bus.resp_hit); end
    n_checks++; if (bus.resp_data !== 4'h9) begin n_fail++; $display("FAIL lookup_data: got %0h expected 9", bus.resp_data); end
    n_checks++; if (wr_en !== 4'b0000) begin n_fail++; $display("FAIL lookup_no_write: got %0h expected 0", wr_en); end
    drive_req(2'd0, 2'd0, 4'h0, 3'd0);
    step();
    n_checks++; if (bus.resp_hit !== 1'b0) begin n_fail++; $display("FAIL lookup_miss_hit: got %0h expected 0", bus.resp_hit); end
    n_checks++; if (bus.resp_data !== 4'h0) begin n_fail++; $display("FAIL lookup_miss_data: got %0h expected 0", bus.resp_data); end
    drive_req(2'd3, 2'd3, 4'h0, 3'd0);
    step();
    n_checks++; if (bus.resp_data !== 4'h2) begin n_fail++; $display("FAIL rsvd_op_data: got %0h expected 2", bus.resp_data); end
    n_checks++; if (wr_en !== 4'b0000) begin n_fail++; $display("FAIL rsvd_op_no_write: got %0h expected 0", wr_en); end
    bus.req_valid = 1'b0;
    step();
    n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL resp_one_cycle: got %0h expected 0", bus.resp_valid); end
  endtask

  task automatic test_insert_empty();
    set_tables({2'd0, 2'd0, 2'd1, 2'd0}, 16'h4321, 4'b1011);
    drive_req(2'd1, 2'd3, 4'hA, 3'd0);
    step();
    n_checks++; if (wr_en !== 4'b0100) begin n_fail++; $display("FAIL ins_empty_wr_en: got %0h expected 4", wr_en); end
    n_checks++; if (wr_adr[2] !== 2'd2) begin n_fail++; $display("FAIL ins_empty_adr: got %0h expected 2", wr_adr[2]); end
    n_checks++; if (wr_key[2] !== 2'd3) begin n_fail++; $display("FAIL ins_empty_key: got %0h expected 3", wr_key[2]); end
    n_checks++; if (wr_data[2] !== 4'hA) begin n_fail++; $display("FAIL ins_empty_data: got %0h expected a", wr_data[2]); end
    n_checks++; if (wr_valid !== 4'b0100) begin n_fail++; $display("FAIL ins_empty_valid: got %0h expected 4", wr_valid); end
    n_checks++; if (bus.resp_fail !== 1'b0) begin n_fail++; $display("FAIL ins_empty_fail: got %0h expected 0", bus.resp_fail); end
    bus.req_valid = 1'b0;
    step();
    n_checks++; if (fwd_updated_mem !== 4'b0100) begin n_fail++; $display("FAIL fwd_mem: got %0h expected 4", fwd_updated_mem); end
    n_checks++; if (fwd_hash_adr[2] !== 2'd2) begin n_fail++; $display("FAIL fwd_adr: got %0h expected 2", fwd_hash_adr[2]); end
    n_checks++; if (fwd_valid !== 4'b0100) begin n_fail++; $display("FAIL fwd_valid: got %0h expected 4", fwd_valid); end
    n_checks++; if (fwd_data[2] !== 4'hA) begin n_fail++; $display("FAIL fwd_data: got %0h expected a", fwd_data[2]); end
    n_checks++; if (wr_en !== 4'b0000) begin n_fail++; $display("FAIL wr_en_drop: got %0h expected 0", wr_en); end
  endtask

  task automatic test_insert_match();
    set_tables({2'd3, 2'd2, 2'd3, 2'd0}, 16'h1111, 4'b1111);
    drive_req(2'd1, 2'd3, 4'h7, 3'd0);
    step();
    n_checks++; if (wr_en !== 4'b0010) begin n_fail++; $display("FAIL ins_match_wr_en: got %0h expected 2", wr_en); end
    n_checks++; if (wr_data[1] !== 4'h7) begin n_fail++; $display("FAIL ins_match_data: got %0h expected 7", wr_data[1]); end
    n_checks++; if (bus.reins_valid !== 1'b0) begin n_fail++; $display("FAIL ins_match_no_evict: got %0h expected 0", bus.reins_valid); end
    bus.req_valid = 1'b0;
    step();
  endtask

  task automatic test_evict();
    // all full: t3 k0 dB, t2 k2 dC, t1 k1 dD, t0 k0 d6
    set_tables({2'd0, 2'd2, 2'd1, 2'd0}, 16'hBCD6, 4'b1111);
    drive_req(2'd1, 2'd3, 4'hE, 3'd0);
    step();
    n_checks++; if (wr_en !== 4'b0001) begin n_fail++; $display("FAIL evict_wr_en: got %0h expected 1", wr_en); end
    n_checks++; if (wr_data[0] !== 4'hE) begin n_fail++; $display("FAIL evict_wr_data: got %0h expected e", wr_data[0]); end
    n_checks++; if ({bus.resp_hit, bus.resp_fail} !== 2'b00) begin n_fail++; $display("FAIL evict_resp: got %0h expected 0", {bus.resp_hit, bus.resp_fail}); end
    n_checks++; if (bus.reins_valid !== 1'b1) begin n_fail++; $display("FAIL evict_reins_valid: got %0h expected 1", bus.reins_valid); end
    n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL evict_ready: got %0h expected 0", bus.req_ready); end
    n_checks++; if (bus.reins_key !== 2'd0) begin n_fail++; $display("FAIL evict_reins_key: got %0h expected 0", bus.reins_key); end
    n_checks++; if (bus.reins_data !== 4'h6) begin n_fail++; $display("FAIL evict_reins_data: got %0h expected 6", bus.reins_data); end
    n_checks++; if (bus.reins_kick !== 3'd1) begin n_fail++; $display("FAIL evict_reins_kick: got %0h expected 1", bus.reins_kick); end
    drive_req(2'd0, 2'd2, 4'h0, 3'd0);
    step();
    n_checks++; if (bus.resp_valid !== 1'b0) begin n_fail++; $display("FAIL stalled_not_consumed: got %0h expected 0", bus.resp_valid); end
    n_checks++; if (bus.reins_data !== 4'h6) begin n_fail++; $display("FAIL stash_stable: got %0h expected 6", bus.reins_data); end
    bus.req_valid   = 1'b0;
    bus.reins_ready = 1'b1;
    #1;
    n_checks++; if (bus.req_ready !== 1'b0) begin n_fail++; $display("FAIL reins_accept_ready: got %0h expected 0", bus.req_ready); end
    step();
    bus.reins_ready = 1'b0;
    n_checks++; if (bus.reins_valid !== 1'b0) begin n_fail++; $display("FAIL reins_done_valid: got %0h expected 0", bus.reins_valid); end
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reins_done_ready: got %0h expected 1", bus.req_ready); end
    // victim advanced to table 1
    drive_req(2'd1, 2'd3, 4'hF, 3'd2);
    step();
    bus.req_valid = 1'b0;
    n_checks++; if (wr_en !== 4'b0010) begin n_fail++; $display("FAIL evict2_wr_en: got %0h expected 2", wr_en); end
    n_checks++; if (bus.reins_data !== 4'hD) begin n_fail++; $display("FAIL evict2_reins_data: got %0h expected d", bus.reins_data); end
    n_checks++; if (bus.reins_kick !== 3'd3) begin n_fail++; $display("FAIL evict2_reins_kick: got %0h expected 3", bus.reins_kick); end
    clk_en          = 1'b0;
    bus.reins_ready = 1'b1;
    step();
    n_checks++; if (bus.reins_valid !== 1'b1) begin n_fail++; $display("FAIL clk_en_hold_reins: got %0h expected 1", bus.reins_valid); end
    n_checks++; if (wr_en !== 4'b0010) begin n_fail++; $display("FAIL clk_en_hold_wr_en: got %0h expected 2", wr_en); end
    n_checks++; if (bus.reins_kick !== 3'd3) begin n_fail++; $display("FAIL clk_en_hold_kick: got %0h expected 3", bus.reins_kick); end
    clk_en = 1'b1;
    step();
    bus.reins_ready = 1'b0;
    n_checks++; if (bus.reins_valid !== 1'b0) begin n_fail++; $display("FAIL clk_en_release: got %0h expected 0", bus.reins_valid); end
  endtask

  task automatic test_kick_limit();
    drive_req(2'd1, 2'd3, 4'h1, 3'd7);
    step();
    n_checks++; if (bus.resp_fail !== 1'b1) begin n_fail++; $display("FAIL kick_limit_fail: got %0h expected 1", bus.resp_fail); end
    n_checks++; if (wr_en !== 4'b0000) begin n_fail++; $display("FAIL kick_limit_no_write: got %0h expected 0", wr_en); end
    n_checks++; if (bus.reins_valid !== 1'b0) begin n_fail++; $display("FAIL kick_limit_no_evict: got %0h expected 0", bus.reins_valid); end
    // victim still table 2
    drive_req(2'd1, 2'd3, 4'h1, 3'd0);
    step();
    bus.req_valid = 1'b0;
    n_checks++; if (wr_en !== 4'b0100) begin n_fail++; $display("FAIL kick_limit_vic_kept: got %0h expected 4", wr_en); end
    n_checks++; if (bus.reins_data !== 4'hC) begin n_fail++; $display("FAIL evict3_reins_data: got %0h expected c", bus.reins_data); end
  endtask

  task automatic test_reset_in_evict();
    rst_b = 1'b0;
    step();
    rst_b = 1'b1;
    n_checks++; if (bus.reins_valid !== 1'b0) begin n_fail++; $display("FAIL rst_evict_reins: got %0h expected 0", bus.reins_valid); end
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_evict_ready: got %0h expected 1", bus.req_ready); end
    n_checks++; if (bus.reins_data !== 4'h0) begin n_fail++; $display("FAIL rst_evict_stash: got %0h expected 0", bus.reins_data); end
    n_checks++; if (wr_en !== 4'b0000) begin n_fail++; $display("FAIL rst_evict_wr_en: got %0h expected 0", wr_en); end
    drive_req(2'd1, 2'd3, 4'h2, 3'd0);
    step();
    bus.req_valid = 1'b0;
    n_checks++; if (wr_en !== 4'b0001) begin n_fail++; $display("FAIL rst_vic_zero: got %0h expected 1", wr_en); end
    bus.reins_ready = 1'b1;
    step();
    bus.reins_ready = 1'b0;
    n_checks++; if (bus.reins_valid !== 1'b0) begin n_fail++; $display("FAIL rst_evict_release: got %0h expected 0", bus.reins_valid); end
  endtask

  task automatic test_delete();
    set_tables({2'd2, 2'd1, 2'd2, 2'd0}, 16'h5678, 4'b1111);
    drive_req(2'd2, 2'd2, 4'h0, 3'd0);
    step();
    n_checks++; if (wr_en !== 4'b0010) begin n_fail++; $display("FAIL delete_wr_en: got %0h expected 2", wr_en); end
    n_checks++; if (wr_valid !== 4'b0000) begin n_fail++; $display("FAIL delete_wr_valid: got %0h expected 0", wr_valid); end
    n_checks++; if (wr_adr[1] !== 2'd3) begin n_fail++; $display("FAIL delete_adr: got %0h expected 3", wr_adr[1]); end
    n_checks++; if (bus.resp_hit !== 1'b1) begin n_fail++; $display("FAIL delete_hit: got %0h expected 1", bus.resp_hit); end
    drive_req(2'd2, 2'd3, 4'h0, 3'd0);
    step();
    bus.req_valid = 1'b0;
    n_checks++; if (wr_en !== 4'b0000) begin n_fail++; $display("FAIL delete_miss_wr_en: got %0h expected 0", wr_en); end
    n_checks++; if (bus.resp_hit !== 1'b0) begin n_fail++; $display("FAIL delete_miss_hit: got %0h expected 0", bus.resp_hit); end
    step();
  endtask

  initial begin
    bus.req_valid    = 1'b0;
    bus.req_op       = 2'd0;
    bus.req_key      = '0;
    bus.req_data     = '0;
    bus.req_kick     = '0;
    bus.req_hash_adr = '0;
    bus.reins_ready  = 1'b0;
    set_tables(8'h00, 16'h0000, 4'b0000);
    test_reset();
    test_lookup();
    test_insert_empty();
    test_insert_match();
    test_evict();
    test_kick_limit();
    test_reset_in_evict();
    test_delete();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
